// File: rtl/dbg_pkg.sv
// Shared constants, state encoding and command decode for the UART debug loader.
package dbg_pkg;

  localparam int DBG_ADR_W = 32;

  // Host command bytes
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_HALT  = 8'h48;  // 'H'
  localparam logic [7:0] CMD_GO    = 8'h47;  // 'G'

  // Reply bytes
  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_BAD   = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR,
    ST_DAT,
    ST_BUS,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE,
    OP_READ,
    OP_CTRL,
    OP_BAD
  } op_t;

  function automatic op_t decode_cmd(input logic [7:0] b);
    case (b)
      CMD_WRITE:        return OP_WRITE;
      CMD_READ:         return OP_READ;
      CMD_HALT, CMD_GO: return OP_CTRL;
      default:          return OP_BAD;
    endcase
  endfunction

endpackage

// File: rtl/dbg_uart_loader_if.sv
// UART byte stream and debug memory bus seen by the loader.
// master = the loader itself, slave = UART/bus environment.
interface dbg_uart_loader_if;
  import dbg_pkg::*;

  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 dbg_mem_op;
  logic [3:0]           dbg_wren;
  logic [DBG_ADR_W-1:0] dbg_adr;
  logic [31:0]          dbg_do;
  logic [31:0]          dbg_di;
  logic                 dbg_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready, dbg_di, dbg_ready,
    output tx_data, tx_valid, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dbg_di, dbg_ready,
    input  tx_data, tx_valid, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );

endinterface

// File: rtl/dbg_shift32.sv
// Little-endian 32-bit byte shift register with a 2-bit byte counter.
// Bytes enter from the MSB side, so after four shifts the first byte sits in [7:0].
// Shifting zeros in drains the word LSB first, which serialises read replies.
module dbg_shift32 (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        clr,     // drop a partial word (counter only)
  input  logic        shift,
  input  logic [7:0]  din,
  input  logic        load,    // parallel load, counter untouched
  input  logic [31:0] word,
  output logic [31:0] value,
  output logic        last     // next shift completes the word
);

  logic [1:0] cnt;

  assign last = (cnt == 2'd3);

  // Word and byte-position registers
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      value <= '0;
      cnt   <= '0;
    end else begin
      if (load)       value <= word;
      else if (shift) value <= {din, value[31:8]};

      if (clr)        cnt <= '0;
      else if (shift) cnt <= cnt + 2'd1;  // wraps 3->0 on the final byte
    end
  end

endmodule

// File: rtl/dbg_uart_loader.sv
// UART command decoder driving the SoC debug memory port and the CPU reset.
// W A0..A3 D0..D3 -> write, reply 'K'; R A0..A3 -> read, reply D0..D3;
// H/G -> hold/release CPU, reply 'K'; anything else -> '?'.
module dbg_uart_loader
  import dbg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit BOOT_HELD      = 1'b0
) (
  input  logic                clk,
  input  logic                n_reset,
  dbg_uart_loader_if.master   bus,
  output logic                cpu_n_reset
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_nxt;
  op_t                op;
  logic [TIMER_W-1:0] timer;
  logic               in_arg, timeout;
  logic               adr_shift, dat_shift, dat_load, abort;
  logic [7:0]         dat_din;
  logic [31:0]        adr_q, dat_q;
  logic               adr_last, dat_last;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               mem_op;
  logic [3:0]         wren;

  dbg_shift32 u_adr (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (abort),
    .shift   (adr_shift),
    .din     (bus.rx_data),
    .load    (1'b0),
    .word    (32'h0),
    .value   (adr_q),
    .last    (adr_last)
  );

  // Holds write data, then the captured read word while it is sent back.
  dbg_shift32 u_dat (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (abort),
    .shift   (dat_shift),
    .din     (dat_din),
    .load    (dat_load),
    .word    (bus.dbg_di),
    .value   (dat_q),
    .last    (dat_last)
  );

  assign in_arg  = (state == ST_ADR) || (state == ST_DAT);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = in_arg && !bus.rx_valid && (timer == TIMER_LAST);

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and per-cycle datapath strobes
  // NOTE: every output gets a default first, so no path through the case leaves a latch.
  always_comb begin
    state_nxt = state;
    adr_shift = 1'b0;
    dat_shift = 1'b0;
    dat_load  = 1'b0;
    dat_din   = bus.rx_data;
    abort     = 1'b0;
    tx_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (decode_cmd(bus.rx_data))
            OP_WRITE, OP_READ: state_nxt = ST_ADR;
            default:           state_nxt = ST_RESP;
          endcase
        end
      end
      ST_ADR: begin
        if (bus.rx_valid) begin
          adr_shift = 1'b1;
          if (adr_last) state_nxt = (op == OP_WRITE) ? ST_DAT : ST_BUS;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DAT: begin
        if (bus.rx_valid) begin
          dat_shift = 1'b1;
          if (dat_last) state_nxt = ST_BUS;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_BUS: begin
        // Incoming bytes are dropped here and in RESP; the host waits for the reply.
        if (bus.dbg_ready) begin
          dat_load  = (op == OP_READ);
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        tx_valid = 1'b1;
        if (bus.tx_ready) begin
          if (op == OP_READ) begin
            dat_shift = 1'b1;
            dat_din   = 8'h00;
            if (dat_last) state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reply byte for the current response position
  always_comb begin
    tx_data = 8'h00;
    if (state == ST_RESP) begin
      case (op)
        OP_READ: tx_data = dat_q[7:0];
        OP_BAD:  tx_data = RSP_BAD;
        default: tx_data = RSP_OK;
      endcase
    end
  end

  // Command latch, bus request, CPU reset control and inter-byte timer
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      op          <= OP_BAD;
      mem_op      <= 1'b0;
      wren        <= 4'h0;
      cpu_n_reset <= !BOOT_HELD;
      timer       <= '0;
    end else begin
      if (state == ST_IDLE && bus.rx_valid) begin
        op <= decode_cmd(bus.rx_data);
        if (bus.rx_data == CMD_HALT) cpu_n_reset <= 1'b0;
        if (bus.rx_data == CMD_GO)   cpu_n_reset <= 1'b1;
      end

      // Request is high for exactly the cycles spent in BUS.
      mem_op <= (state_nxt == ST_BUS);
      if (state != ST_BUS && state_nxt == ST_BUS)
        wren <= (op == OP_WRITE) ? 4'hF : 4'h0;

      if (in_arg && !bus.rx_valid && !timeout) timer <= timer + 1'b1;
      else                                     timer <= '0;
    end
  end

  assign bus.tx_valid   = tx_valid;
  assign bus.tx_data    = tx_data;
  assign bus.dbg_mem_op = mem_op;
  assign bus.dbg_wren   = wren;
  assign bus.dbg_adr    = adr_q;
  assign bus.dbg_do     = dat_q;

endmodule

// File: tb/tb_dbg_uart_loader.sv
// Randomised bench for dbg_uart_loader: a bus responder and a UART TX sink run
// alongside the command driver; expected ops and replies come from the protocol rules.
module tb_dbg_uart_loader;
  import dbg_pkg::*;

  localparam int TO = 40;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  wren;
  } op_rec_t;

  logic clk = 1'b0;
  logic n_reset;
  logic cpu_n_reset, cpu_n_reset0;

  dbg_uart_loader_if bus ();
  dbg_uart_loader_if bus0 ();

  dbg_uart_loader #(.TIMEOUT_CYCLES(TO), .BOOT_HELD(1'b1)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus), .cpu_n_reset(cpu_n_reset)
  );

  dbg_uart_loader #(.TIMEOUT_CYCLES(TO), .BOOT_HELD(1'b0)) dut0 (
    .clk(clk), .n_reset(n_reset), .bus(bus0), .cpu_n_reset(cpu_n_reset0)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  tx_q[$];
  op_rec_t     op_q[$];
  logic [31:0] di_q[$];
  bit          tx_stall  = 1'b0;
  bit          resp_hold = 1'b0;
  int          resp_lat  = -1;
  bit          use_di    = 1'b0;
  logic [31:0] next_di   = '0;
  int          gap_max   = 6;
  logic        exp_cpu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    bus0.rx_data = '0; bus0.rx_valid = 1'b0; bus0.tx_ready = 1'b0;
    bus0.dbg_di  = '0; bus0.dbg_ready = 1'b0;
  end

  // Bus responder: random latency (or held), random read data, occasional stray ready.
  initial begin
    op_rec_t     o;
    int          lat, n;
    logic [31:0] di;
    bus.dbg_ready = 1'b0;
    bus.dbg_di    = '0;
    forever begin
      @(negedge clk);
      bus.dbg_ready = 1'b0;
      if (bus.dbg_mem_op) begin
        o.adr  = bus.dbg_adr;
        o.dat  = bus.dbg_do;
        o.wren = bus.dbg_wren;
        lat    = (resp_lat >= 0) ? resp_lat : int'($urandom_range(0, 3));
        n      = 0;
        while ((n < lat || resp_hold) && bus.dbg_mem_op) begin
          @(negedge clk);
          n++;
        end
        if (bus.dbg_mem_op) begin
          check("bus_adr_stable", bus.dbg_adr, o.adr);
          check("bus_do_stable", bus.dbg_do, o.dat);
          check("bus_wren_stable", 32'(bus.dbg_wren), 32'(o.wren));
          di = use_di ? next_di : $urandom;
          bus.dbg_di    = di;
          bus.dbg_ready = 1'b1;
          op_q.push_back(o);
          di_q.push_back(di);
          @(negedge clk);
          bus.dbg_ready = 1'b0;
          check("mem_op_drop", 32'(bus.dbg_mem_op), 32'd0);
          check("ready_to_tx", 32'(bus.tx_valid), 32'd1);
        end
      end else begin
        bus.dbg_ready = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // TX sink: random back-pressure, records accepted bytes, checks held data.
  initial begin
    logic       pv, pr;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pd = '0;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pv && !pr && n_reset) begin
        check("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
        check("tx_hold_data", 32'(bus.tx_data), 32'(pd));
      end
      bus.tx_ready = !tx_stall && ($urandom_range(0, 3) != 0);
      if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
      pv = bus.tx_valid; pr = bus.tx_ready; pd = bus.tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    if (gap) repeat ($urandom_range(0, gap_max)) @(negedge clk);
  endtask

  task automatic clear_q();
    tx_q.delete();
    op_q.delete();
    di_q.delete();
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (tx_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("tx_count", tx_q.size(), n);
  endtask

  task automatic send_word(input logic [31:0] w, input bit last_gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], (i < 3) || last_gap);
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat);
    op_rec_t o;
    send_byte(CMD_WRITE, 1'b1);
    send_word(adr, 1'b1);
    send_word(dat, 1'b0);
    check("w_op_latency", 32'(bus.dbg_mem_op), 32'd1);
    wait_tx(1);
    check("w_op_count", op_q.size(), 1);
    if (op_q.size() > 0) begin
      o = op_q.pop_front();
      check("w_adr", o.adr, adr);
      check("w_do", o.dat, dat);
      check("w_wren", 32'(o.wren), 32'hF);
    end
    if (tx_q.size() > 0) check("w_reply", 32'(tx_q[0]), 32'(RSP_OK));
    check("w_cpu", 32'(cpu_n_reset), 32'(exp_cpu));
    clear_q();
  endtask

  task automatic do_read(input logic [31:0] adr);
    op_rec_t     o;
    logic [31:0] di;
    send_byte(CMD_READ, 1'b1);
    send_word(adr, 1'b0);
    check("r_op_latency", 32'(bus.dbg_mem_op), 32'd1);
    wait_tx(4);
    check("r_op_count", op_q.size(), 1);
    if (op_q.size() > 0 && di_q.size() > 0) begin
      o  = op_q.pop_front();
      di = di_q.pop_front();
      check("r_adr", o.adr, adr);
      check("r_wren", 32'(o.wren), 32'h0);
      for (int i = 0; i < 4 && i < tx_q.size(); i++)
        check($sformatf("r_byte%0d", i), 32'(tx_q[i]), 32'(di[8*i +: 8]));
    end
    check("r_cpu", 32'(cpu_n_reset), 32'(exp_cpu));
    clear_q();
  endtask

  // H, G or an unknown byte: single-byte command, single-byte reply, no bus op.
  task automatic do_single(input logic [7:0] b);
    logic [7:0] exp_rsp;
    exp_rsp = RSP_BAD;
    if (b == CMD_HALT) begin exp_cpu = 1'b0; exp_rsp = RSP_OK; end
    if (b == CMD_GO)   begin exp_cpu = 1'b1; exp_rsp = RSP_OK; end
    send_byte(b, 1'b1);
    wait_tx(1);
    if (tx_q.size() > 0) check("s_reply", 32'(tx_q[0]), 32'(exp_rsp));
    check("s_no_op", op_q.size(), 0);
    check("s_cpu", 32'(cpu_n_reset), 32'(exp_cpu));
    clear_q();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({pfx, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({pfx, "_mem_op"}, 32'(bus.dbg_mem_op), 32'd0);
    check({pfx, "_wren"}, 32'(bus.dbg_wren), 32'd0);
    check({pfx, "_adr"}, bus.dbg_adr, 32'd0);
    check({pfx, "_do"}, bus.dbg_do, 32'd0);
    check({pfx, "_cpu"}, 32'(cpu_n_reset), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int         t, kind;
    n_reset = 1'b0;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    exp_cpu = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_cpu_boot_free", 32'(cpu_n_reset0), 32'd1);
    n_reset = 1'b1;
    @(negedge clk);
    check("boot_free_idle_tx", 32'(bus0.tx_valid), 32'd0);
    check("boot_free_idle_op", 32'(bus0.dbg_mem_op), 32'd0);

    // Write to 0x20000 with a three-cycle bus latency
    resp_lat = 3;
    do_write(32'h0002_0000, 32'h0000_006F);
    resp_lat = -1;

    // Read 0x20004, fixed read word
    use_di = 1'b1; next_di = 32'h0000_0001;
    do_read(32'h0002_0004);
    use_di = 1'b0;

    // CPU hold/release
    do_single(CMD_GO);
    do_single(CMD_HALT);

    // Stalled command aborts silently, next command still works
    send_byte(CMD_WRITE, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (TO + 10) @(negedge clk);
    check("to_no_op", op_q.size(), 0);
    check("to_no_tx", tx_q.size(), 0);
    clear_q();
    do_write(32'h0002_0008, 32'h0000_0002);

    // Unknown byte, then bytes arriving during BUS and RESP are dropped
    do_single(8'h5A);
    tx_stall = 1'b1; resp_hold = 1'b1;
    send_byte(CMD_READ, 1'b1);
    send_word(32'h0000_1235, 1'b0);
    t = 0;
    while (!bus.dbg_mem_op && t < 50) begin @(negedge clk); t++; end
    check("drop_bus_seen", 32'(bus.dbg_mem_op), 32'd1);
    for (int j = 0; j < 3; j++) send_byte(CMD_WRITE, 1'b0);
    resp_hold = 1'b0;
    t = 0;
    while (!bus.tx_valid && t < 50) begin @(negedge clk); t++; end
    check("drop_resp_seen", 32'(bus.tx_valid), 32'd1);
    for (int j = 0; j < 3; j++) send_byte(CMD_GO, 1'b0);
    tx_stall = 1'b0;
    wait_tx(4);
    check("drop_op_count", op_q.size(), 1);
    if (di_q.size() > 0)
      for (int i = 0; i < 4 && i < tx_q.size(); i++)
        check("drop_byte", 32'(tx_q[i]), 32'(di_q[0][8*i +: 8]));
    check("drop_cpu", 32'(cpu_n_reset), 32'(exp_cpu));
    clear_q();
    do_write(32'h0000_0040, 32'hA5A5_0F0F);

    // Random command mix
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: do_write($urandom, $urandom);
        1: do_read($urandom);
        2: do_single(CMD_HALT);
        3: do_single(CMD_GO);
        default: begin
          do b = 8'($urandom_range(0, 255));
          while (b == CMD_WRITE || b == CMD_READ || b == CMD_HALT || b == CMD_GO);
          do_single(b);
        end
      endcase
    end

    // Reset pulse in the middle of a bus op
    do_single(CMD_GO);
    resp_hold = 1'b1;
    send_byte(CMD_WRITE, 1'b1);
    send_word(32'h0003_0000, 1'b1);
    send_word(32'h1122_3344, 1'b0);
    t = 0;
    while (!bus.dbg_mem_op && t < 50) begin @(negedge clk); t++; end
    check("rst_mid_op_seen", 32'(bus.dbg_mem_op), 32'd1);
    n_reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    n_reset = 1'b1;
    resp_hold = 1'b0;
    exp_cpu = 1'b0;
    repeat (2) @(negedge clk);
    clear_q();
    do_write(32'h0000_0100, 32'hDEAD_BEEF);
    do_read(32'h0000_0103);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
